// File: rtl/load_store_unit.sv
// Load/store unit: aligns core loads/stores onto a word-addressed valid/ready
// bus with byte enables, extends load data, and aborts stuck accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned CW  = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic [BEW-1:0]  be_q;
  logic [DW-1:0]   wdata_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   rdata_q;
  logic            buserr_q;

  logic            req_c, illegal_c, accept_c, capture_c, abort_c, timeout_c;
  logic [1:0]      off_c;
  logic [BEW-1:0]  be_c;
  logic [DW-1:0]   wdata_c, shifted_c, load_c;

  // Request decode: lane pattern, replicated store data and legality.
  always_comb begin
    req_c     = MemRead | MemWrite;
    off_c     = ALUResult[1:0];
    be_c      = 4'b1111;
    wdata_c   = WriteData;
    illegal_c = 1'b0;
    case (Funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_c      = 4'b0011 << off_c;
        wdata_c   = {2{WriteData[15:0]}};
        illegal_c = off_c[0];
      end
      default: illegal_c = (off_c != 2'b00);
    endcase
    if (MemWrite) begin
      illegal_c = illegal_c | Funct3[2];
    end else if ((Funct3 == 3'b011) || (Funct3[2:1] == 2'b11)) begin
      illegal_c = 1'b1;
    end
  end

  // Load data extraction from the returned word.
  always_comb begin
    shifted_c = bus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  load_c = {24'b0, shifted_c[7:0]};
      3'b101:  load_c = {16'b0, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  assign timeout_c = (cnt_q >= CNT_LAST);

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    capture_c   = 1'b0;
    abort_c     = 1'b0;
    Stall       = 1'b0;
    MisalignErr = 1'b0;
    BusErr      = 1'b0;
    ReadData    = '0;
    bus_valid   = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_be      = '0;
    case (state)
      IDLE: begin
        if (req_c) begin
          if (illegal_c) begin
            MisalignErr = 1'b1;
          end else begin
            Stall     = 1'b1;
            accept_c  = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        Stall     = 1'b1;
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        bus_be    = be_q;
        if (bus_ready) begin
          state_nxt = we_q ? DONE : RESP;
        end else if (timeout_c) begin
          abort_c   = 1'b1;
          state_nxt = DONE;
        end
      end
      RESP: begin
        Stall = 1'b1;
        if (bus_rvalid) begin
          capture_c = 1'b1;
          state_nxt = DONE;
        end else if (timeout_c) begin
          abort_c   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ReadData  = rdata_q;
        BusErr    = buserr_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The reset cycle presents a quiet interface regardless of state.
    if (reset) begin
      Stall       = 1'b0;
      MisalignErr = 1'b0;
      BusErr      = 1'b0;
      ReadData    = '0;
      bus_valid   = 1'b0;
      bus_we      = 1'b0;
      bus_addr    = '0;
      bus_wdata   = '0;
      bus_be      = '0;
    end
  end

  // State, access latches, timeout counter and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        addr_q   <= {ALUResult[31:2], 2'b00};
        be_q     <= be_c;
        wdata_q  <= wdata_c;
        we_q     <= MemWrite;
        f3_q     <= Funct3;
        off_q    <= off_c;
        cnt_q    <= '0;
        rdata_q  <= '0;
        buserr_q <= 1'b0;
      end else if ((state == REQ) || (state == RESP)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (capture_c) rdata_q <= load_c;
      if (abort_c) buserr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus randomized accesses
// checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, MisalignErr, BusErr;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int nvec = 0;
  int nerr = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .MisalignErr(MisalignErr),
    .BusErr(BusErr), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_illegal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (wr && f3[2]) return 1'b1;
    if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int lanes;
    lanes = ((1 << size_of(f3)) - 1) << (a % 4);
    return lanes & 32'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (size_of(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (size_of(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (a % 4));
    if (size_of(f3) == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (size_of(f3) == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // One access from IDLE through DONE; dr/dv are REQ/RESP cycles before ready/rvalid.
  task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int dr, input int dv, input logic [31:0] rdat);
    bit          ill;
    bit          hs;
    bit          got;
    bit          exp_err;
    int          cyc;
    logic [31:0] exp_rd;
    ill     = is_illegal(wr, f3, a);
    hs      = 1'b0;
    got     = 1'b0;
    exp_err = 1'b0;
    cyc     = 0;
    exp_rd  = '0;

    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd;
    bus_ready = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    #1;
    check("idle_misalign", 32'(MisalignErr), 32'(ill));
    check("idle_stall", 32'(Stall), 32'(!ill));
    check("idle_valid", 32'(bus_valid), 0);
    check("idle_rdata", ReadData, 0);
    if (ill) begin
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; bus_rvalid = 1'b0;
      #1;
      check("ill_valid", 32'(bus_valid), 0);
      check("ill_stall", 32'(Stall), 0);
      return;
    end

    for (int k = 0; !hs && !exp_err; k++) begin
      @(negedge clk);
      ALUResult = $urandom; WriteData = $urandom; Funct3 = 3'($urandom);
      bus_ready  = (k == dr);
      bus_rvalid = (k == dr) ? 1'b1 : 1'($urandom);
      bus_rdata  = $urandom;
      #1;
      cyc++;
      check("req_valid", 32'(bus_valid), 1);
      check("req_stall", 32'(Stall), 1);
      check("req_we", 32'(bus_we), 32'(wr));
      check("req_addr", bus_addr, a & 32'hFFFFFFFC);
      check("req_be", 32'(bus_be), exp_be(f3, a));
      if (wr) check("req_wdata", bus_wdata, exp_wdata(f3, wd));
      if (k == dr) hs = 1'b1;
      else if (cyc == TO) exp_err = 1'b1;
    end

    if (hs && !wr) begin
      for (int j = 0; !got && !exp_err; j++) begin
        @(negedge clk);
        bus_ready  = 1'($urandom);
        bus_rvalid = (j == dv);
        bus_rdata  = (j == dv) ? rdat : $urandom;
        #1;
        cyc++;
        check("resp_valid", 32'(bus_valid), 0);
        check("resp_stall", 32'(Stall), 1);
        if (j == dv) got = 1'b1;
        else if (cyc >= TO) exp_err = 1'b1;
      end
    end
    if (got) exp_rd = exp_load(f3, a, rdat);

    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    bus_ready = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    #1;
    check("done_stall", 32'(Stall), 0);
    check("done_rdata", ReadData, exp_rd);
    check("done_buserr", 32'(BusErr), 32'(exp_err));
    check("done_valid", 32'(bus_valid), 0);

    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("post_rdata", ReadData, 0);
    check("post_buserr", 32'(BusErr), 0);
    check("post_stall", 32'(Stall), 0);
    check("post_valid", 32'(bus_valid), 0);
  endtask

  initial begin
    bit          rd, wr;
    logic [2:0]  f3;
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b111;
    ALUResult = 32'h3; WriteData = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(bus_valid), 0);
    check("rst_we", 32'(bus_we), 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_be", 32'(bus_be), 0);
    check("rst_rdata", ReadData, 0);
    check("rst_misalign", 32'(MisalignErr), 0);
    check("rst_buserr", 32'(BusErr), 0);
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0;
    #1;
    check("rst_stall", 32'(Stall), 0);

    do_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0);
    do_txn(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 1, 32'h80112233);
    do_txn(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 2, 0, 32'h80112233);
    do_txn(1'b0, 1'b1, 3'b001, 32'h201, 32'h1234, 0, 0, 32'h0);
    do_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 100, 0, 32'h55AA55AA);
    do_txn(1'b1, 1'b1, 3'b000, 32'h502, 32'hA5, 0, 0, 32'h0);
    do_txn(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 3, 0, 32'hCAFEF00D);
    do_txn(1'b1, 1'b0, 3'b010, 32'h604, 32'h0, 1, 1, 32'hCAFEF00D);

    // Reset while waiting for read data abandons the access.
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    #1;
    check("rr_idle_stall", 32'(Stall), 1);
    @(negedge clk);
    bus_ready = 1'b1;
    #1;
    check("rr_req_valid", 32'(bus_valid), 1);
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    check("rr_resp_stall", 32'(Stall), 1);
    check("rr_resp_valid", 32'(bus_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rr_rst_valid", 32'(bus_valid), 0);
    check("rr_rst_rdata", ReadData, 0);
    check("rr_rst_buserr", 32'(BusErr), 0);
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    #1;
    check("rr_idle_stall2", 32'(Stall), 0);
    check("rr_idle_rdata", ReadData, 0);
    check("rr_idle_valid", 32'(bus_valid), 0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("rr_nodone_rdata", ReadData, 0);
    check("rr_nodone_buserr", 32'(BusErr), 0);
    check("rr_nodone_stall", 32'(Stall), 0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      f3 = 3'($urandom);
      if (wr && f3 == 3'b011) f3 = 3'b010;
      do_txn(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 5),
             $urandom_range(0, 4), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
